// File: rtl/bcd_conv_pkg.sv
// Shared types and defaults for the BCD converter arbiter slice.
package bcd_conv_pkg;

  localparam int BCD_W       = 12;
  localparam int BIN_W       = 10;
  localparam int TIMEOUT_DEF = 40;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_CHK   = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5,
    S_COOL  = 3'd6
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first request at or above ptr, wrapping at N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[(int'(ptr) + k) % N_REQ]) begin
        any = 1'b1;
        gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
        idx = PW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one BCD-to-binary converter among N_REQ requesters: round-robin grant,
// digit check, St/Done sequencing with timeout, one-cycle response to the grantee.
module bcd_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int BCD_W   = bcd_conv_pkg::BCD_W,
  parameter int BIN_W   = bcd_conv_pkg::BIN_W,
  parameter int TIMEOUT = bcd_conv_pkg::TIMEOUT_DEF
) (
  input  logic                   CLK,
  input  logic                   Rst_n,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*BCD_W-1:0] Req_BCD,
  output logic [N_REQ-1:0]       Gnt,
  output logic [N_REQ-1:0]       Rsp_Valid,
  output logic [BIN_W-1:0]       Rsp_Binary,
  output logic                   Rsp_Err,
  output logic                   Conv_St,
  output logic [BCD_W-1:0]       Conv_BCD,
  input  logic                   Conv_Done,
  input  logic [BIN_W-1:0]       Conv_Binary,
  output logic                   Busy
);
  import bcd_conv_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int ND = BCD_W / 4;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, win_idx;
  logic [N_REQ-1:0] win, gnt_q;
  logic             any_req, done_q, done_edge, bad_digit, busy_q, cool_lo;
  logic [CW-1:0]    cnt, cnt_inc;
  logic             to_hit;
  logic [BCD_W-1:0] bcd_q;
  logic [BIN_W-1:0] res_q;
  logic             err_q;
  logic [ND-1:0]    dig_bad;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
    .req(Req), .ptr(ptr), .gnt(win), .idx(win_idx), .any(any_req)
  );

  for (genvar d = 0; d < ND; d++) begin : g_dig
    assign dig_bad[d] = (bcd_q[4*d +: 4] > 4'd9);
  end
  assign bad_digit = |dig_bad;

  // Done is only trusted on its rising edge so a level left over from an
  // earlier conversion cannot complete the current one.
  always_ff @(posedge CLK) done_q <= Conv_Done;
  assign done_edge = Conv_Done & ~done_q;

  assign cnt_inc = (cnt == CW'(TIMEOUT)) ? cnt : cnt + CW'(1);
  assign to_hit  = (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|Req) state_nxt = S_ARB;
      S_ARB:   state_nxt = any_req ? S_CHK : S_IDLE;
      S_CHK:   state_nxt = bad_digit ? S_RESP : S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (done_edge || to_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_COOL;
      S_COOL:  if (cool_lo) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Rst_n) begin
      // A converter still showing Done must drain before it can be restarted.
      state   <= Conv_Done ? S_COOL : S_IDLE;
      ptr     <= '0;
      gnt_q   <= '0;
      bcd_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      cool_lo <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy_q  <= (state_nxt != S_IDLE);
      cool_lo <= (state == S_COOL) && !cool_lo && !Conv_Done;
      case (state)
        S_ARB: if (any_req) begin
          gnt_q <= win;
          bcd_q <= Req_BCD[int'(win_idx)*BCD_W +: BCD_W];
          ptr   <= (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + PW'(1);
        end
        S_CHK: if (bad_digit) begin
          res_q <= '0;
          err_q <= 1'b1;
        end
        S_START: begin
          cnt   <= '0;
          res_q <= '0;
          err_q <= 1'b0;
        end
        S_WAIT: begin
          cnt <= cnt_inc;
          if (done_edge) begin
            res_q <= Conv_Binary;
            err_q <= 1'b0;
          end else if (to_hit) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        S_RESP: gnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign Gnt        = gnt_q;
  assign Rsp_Valid  = (state == S_RESP) ? gnt_q : '0;
  assign Rsp_Binary = (state == S_RESP) ? res_q : '0;
  assign Rsp_Err    = (state == S_RESP) & err_q;
  assign Conv_St    = (state == S_START);
  assign Conv_BCD   = bcd_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed + randomized bench for bcd_conv_arbiter with a behavioural converter.
module tb_bcd_conv_arbiter;
  localparam int TIMEOUT = 40;

  logic        CLK = 1'b0;
  logic        Rst_n;
  logic [3:0]  Req;
  logic [47:0] Req_BCD;
  logic [3:0]  Gnt, Rsp_Valid;
  logic [9:0]  Rsp_Binary;
  logic        Rsp_Err, Conv_St, Busy;
  logic [11:0] Conv_BCD;
  logic        Conv_Done = 1'b0;
  logic [9:0]  Conv_Binary = '0;

  int checks = 0, errors = 0, cyc = 0, mp = 0;
  int st_cnt = 0, st_cyc = 0, rv_cnt = 0, rv_cyc = 0, b2b_cnt = 0;
  bit prev_rv = 1'b0;
  int lat_len = 4, hold_len = 2, cv_cnt = 0, cv_hold = 0;
  bit cv_dead = 1'b0;
  logic [9:0]  cv_val = '0;
  logic [11:0] rbcd;
  bit got;
  int rv0, b0;

  bcd_conv_arbiter #(.N_REQ(4), .BCD_W(12), .BIN_W(10), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Rst_n(Rst_n), .Req(Req), .Req_BCD(Req_BCD), .Gnt(Gnt),
    .Rsp_Valid(Rsp_Valid), .Rsp_Binary(Rsp_Binary), .Rsp_Err(Rsp_Err),
    .Conv_St(Conv_St), .Conv_BCD(Conv_BCD), .Conv_Done(Conv_Done),
    .Conv_Binary(Conv_Binary), .Busy(Busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int bcd2dec(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Converter: latency lat_len after St, then Done held hold_len cycles.
  always @(posedge CLK) begin
    if (cv_hold > 0) begin
      cv_hold <= cv_hold - 1;
      if (cv_hold == 1) Conv_Done <= 1'b0;
    end else if (cv_cnt > 0) begin
      cv_cnt <= cv_cnt - 1;
      if (cv_cnt == 1 && !cv_dead) begin
        Conv_Done   <= 1'b1;
        Conv_Binary <= cv_val;
        cv_hold     <= hold_len;
      end
    end else if (Conv_St) begin
      cv_cnt <= lat_len;
      cv_val <= 10'(bcd2dec(Conv_BCD));
    end
  end

  always @(negedge CLK) begin
    if (Conv_St) begin
      st_cnt <= st_cnt + 1;
      st_cyc <= cyc;
    end
    if (Rsp_Valid != 0) begin
      rv_cnt <= rv_cnt + 1;
      if (prev_rv) b2b_cnt <= b2b_cnt + 1;
    end
    prev_rv <= (Rsp_Valid != 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input logic [3:0] eg, input bit eerr,
                     input logic [9:0] ebin, input bit drop);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge CLK);
      seen = (Gnt != 0);
    end
    chk({tag, "_gnt_seen"}, 32'(seen), 1);
    chk({tag, "_gnt"}, 32'(Gnt), 32'(eg));
    if (drop) Req = '0;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge CLK);
      seen = (Rsp_Valid != 0);
    end
    rv_cyc = cyc;
    chk({tag, "_rv_seen"}, 32'(seen), 1);
    chk({tag, "_rv"}, 32'(Rsp_Valid), 32'(eg));
    chk({tag, "_err"}, 32'(Rsp_Err), 32'(eerr));
    chk({tag, "_bin"}, 32'(Rsp_Binary), 32'(ebin));
  endtask

  // Reference: round-robin from mp over the current Req, decimal value of the
  // winner's digits, error on a non-decimal digit, dead converter or late Done.
  task automatic run_model(input string tag, input bit drop);
    int w, st0;
    logic [11:0] b;
    bit bad, eerr;
    logic [9:0] ebin;
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && Req[(mp + k) % 4]) w = (mp + k) % 4;
    if (w < 0) w = 0;
    b    = Req_BCD[w*12 +: 12];
    bad  = (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    eerr = bad || cv_dead || (lat_len >= TIMEOUT);
    ebin = eerr ? 10'd0 : 10'(bcd2dec(b));
    st0  = st_cnt;
    txn(tag, 4'(1 << w), eerr, ebin, drop);
    mp = (w + 1) % 4;
    chk({tag, "_st"}, 32'(st_cnt - st0), bad ? 0 : 1);
    if (!bad) chk({tag, "_lat"}, 32'(rv_cyc - st_cyc), eerr ? TIMEOUT + 1 : lat_len + 2);
  endtask

  task automatic rst_outs(input string tag);
    chk({tag, "_gnt_rv"}, 32'({Rsp_Valid, Gnt}), 0);
    chk({tag, "_rsp"}, 32'({Rsp_Err, Rsp_Binary}), 0);
    chk({tag, "_conv"}, 32'({Conv_St, Conv_BCD}), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    Req   = '0;
    repeat (2) @(negedge CLK);
    Rst_n = 1'b1;
    mp    = 0;
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 200 && !idle; n++) begin
      @(negedge CLK);
      idle = !Busy && !Conv_Done;
    end
    chk({tag, "_idle"}, 32'(idle), 1);
  endtask

  initial begin
    Rst_n = 1'b0;
    Req = '0;
    Req_BCD = '0;
    repeat (3) @(negedge CLK);
    rst_outs("reset");
    Rst_n = 1'b1;

    // single requester
    Req_BCD[11:0] = 12'h255;
    lat_len = 6;
    Req = 4'b0001;
    run_model("t1", 1'b0);
    Req = '0;

    // all requesters held: strict rotation 0,1,2,3,0
    do_reset();
    Req_BCD = {12'h500, 12'h999, 12'h010, 12'h001};
    Req = 4'b1111;
    b0 = b2b_cnt;
    for (int i = 0; i < 5; i++) begin
      lat_len = 2 + i;
      run_model($sformatf("t2_%0d", i), 1'b0);
    end
    chk("t2_b2b", 32'(b2b_cnt - b0), 0);

    // bad digit: no converter start
    Req_BCD[23:12] = 12'h1A3;
    Req = 4'b0010;
    run_model("t3", 1'b0);

    // dead converter, then recovery; Done/timeout tie and just-late Done
    Req_BCD[11:0] = 12'h042;
    Req = 4'b0001;
    lat_len = 5;
    cv_dead = 1'b1;
    run_model("t4_to", 1'b0);
    cv_dead = 1'b0;
    run_model("t4_ok", 1'b0);
    lat_len = TIMEOUT - 1;
    run_model("t4_tie", 1'b0);
    lat_len = TIMEOUT;
    run_model("t4_late", 1'b0);
    lat_len = 4;
    Req = '0;

    // Req dropped after grant still gets its response
    Req_BCD[35:24] = 12'h707;
    Req = 4'b0100;
    run_model("t5a", 1'b1);

    // Req pulse withdrawn before ARB: no grant
    wait_idle("t5b");
    Req = 4'b0001;
    @(negedge CLK);
    Req = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("t5b_nognt", 32'(Gnt), 0);
    end
    chk("t5b_busy", 32'(Busy), 0);

    // randomized traffic
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < 4; s++) begin
        rbcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 9) == 0) rbcd[7:4] = 4'($urandom_range(10, 15));
        Req_BCD[s*12 +: 12] = rbcd;
      end
      Req      = 4'($urandom_range(1, 15));
      lat_len  = $urandom_range(1, 12);
      hold_len = $urandom_range(1, 4);
      run_model($sformatf("rnd%0d", r), 1'b0);
    end
    Req = '0;

    // reset while the converter raises Done: abort, drain, then convert 999
    wait_idle("t6");
    lat_len = 5;
    hold_len = 6;
    Req_BCD[11:0] = 12'h123;
    Req = 4'b0001;
    rv0 = rv_cnt;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge CLK);
      got = Conv_Done;
    end
    chk("t6_done_seen", 32'(got), 1);
    Rst_n = 1'b0;
    Req = '0;
    @(negedge CLK);
    rst_outs("t6_rst");
    Rst_n = 1'b1;
    mp = 0;
    Req_BCD[11:0] = 12'h999;
    Req = 4'b0001;
    for (int n = 0; n < 20 && Conv_Done; n++) begin
      chk("t6_cool_nognt", 32'(Gnt), 0);
      @(negedge CLK);
    end
    chk("t6_no_rv", 32'(rv_cnt - rv0), 0);
    hold_len = 2;
    run_model("t6", 1'b0);
    Req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
